// File: rtl/emds_link_sequencer.sv
// rtl/emds_link_sequencer.sv - password-gated serial transmit sequencer (start, 8 data LSB-first, stop)
// Optional even-parity bit between data and stop when EMDS_PARITY_EN is defined.
module emds_link_sequencer #(
  parameter logic [3:0] PASSWORD  = 4'b0101,
  parameter int         MAX_TRIES = 3
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_password,
  input  logic       i_pwd_valid,
  input  logic       i_lock_req,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_line_out,
  output logic       o_byte_done,
  output logic       o_busy,
  output logic       o_unlocked,
  output logic       o_locked_out
);

`ifdef EMDS_PARITY_EN
  typedef enum logic [2:0] {S_LOCKED, S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_LOCKOUT} state_t;
`else
  typedef enum logic [2:0] {S_LOCKED, S_IDLE, S_START, S_DATA, S_STOP, S_LOCKOUT} state_t;
`endif

  state_t     r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_fail_cnt;
  logic       r_parity;
  logic       r_lock_seen;
  logic       r_line_out;
  logic       r_byte_done;
  logic       r_busy;
  logic       r_unlocked;
  logic       r_locked_out;
  logic [3:0] w_fail_next;

  assign w_fail_next  = r_fail_cnt + 4'd1;
  assign o_tx_ready   = (r_state == S_IDLE) & ~i_lock_req;
  assign o_line_out   = r_line_out;
  assign o_byte_done  = r_byte_done;
  assign o_busy       = r_busy;
  assign o_unlocked   = r_unlocked;
  assign o_locked_out = r_locked_out;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_LOCKED;
      r_shreg      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_fail_cnt   <= 4'd0;
      r_parity     <= 1'b0;
      r_lock_seen  <= 1'b0;
      r_line_out   <= 1'b1;
      r_byte_done  <= 1'b0;
      r_busy       <= 1'b0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      // A relock request during a frame is remembered and honoured after the stop bit.
      if (r_busy && i_lock_req) r_lock_seen <= 1'b1;
      case (r_state)
        S_LOCKED: begin
          r_line_out <= 1'b1;
          if (i_pwd_valid) begin
            if (i_password == PASSWORD) begin
              r_state    <= S_IDLE;
              r_unlocked <= 1'b1;
              r_fail_cnt <= 4'd0;
            end else begin
              r_fail_cnt <= w_fail_next;
              if (w_fail_next == 4'(MAX_TRIES)) begin
                r_state      <= S_LOCKOUT;
                r_locked_out <= 1'b1;
              end
            end
          end
        end
        S_IDLE: begin
          if (i_lock_req) begin
            r_state    <= S_LOCKED;
            r_unlocked <= 1'b0;
          end else if (i_tx_valid) begin
            r_shreg     <= i_tx_data;
            r_parity    <= ^i_tx_data;
            r_lock_seen <= 1'b0;
            r_busy      <= 1'b1;
            r_line_out  <= 1'b0;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_line_out <= r_shreg[0];
          r_shreg    <= r_shreg >> 1;
          r_bit_cnt  <= 3'd0;
          r_state    <= S_DATA;
        end
        S_DATA: begin
          if (r_bit_cnt == 3'd7) begin
            r_bit_cnt <= 3'd0;
`ifdef EMDS_PARITY_EN
            r_line_out <= r_parity;
            r_state    <= S_PAR;
`else
            r_line_out  <= 1'b1;
            r_byte_done <= 1'b1;
            r_state     <= S_STOP;
`endif
          end else begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_line_out <= r_shreg[0];
            r_shreg    <= r_shreg >> 1;
          end
        end
`ifdef EMDS_PARITY_EN
        S_PAR: begin
          r_line_out  <= 1'b1;
          r_byte_done <= 1'b1;
          r_state     <= S_STOP;
        end
`endif
        S_STOP: begin
          r_byte_done <= 1'b0;
          r_busy      <= 1'b0;
          r_lock_seen <= 1'b0;
          if (r_lock_seen || i_lock_req) begin
            r_state    <= S_LOCKED;
            r_unlocked <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          r_line_out   <= 1'b1;
          r_locked_out <= 1'b1;
        end
        default: r_state <= S_LOCKED;
      endcase
    end
  end

endmodule
